// File: rtl/serial_cmp2_pkg.sv
// Shared types and helpers for the serial_cmp2 bit-serial magnitude comparator.
package serial_cmp2_pkg;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // Pair-counter width: clog2(width/2), never below one bit.
   function automatic int cnt_w(input int width);
      int pairs;
      int w;
      pairs = width / 2;
      w = 0;
      while ((1 << w) < pairs) w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_cmp2_slice.sv
// Combinational 2-bit cascade compare slice (module cmp2_slice).
module cmp2_slice (
   input  logic a1,
   input  logic a0,
   input  logic b1,
   input  logic b0,
   input  logic eq,
   input  logic gt,
   output logic eq_o,
   output logic gt_o
);

   logic [1:0] pa;
   logic [1:0] pb;

   assign pa   = {a1, a0};
   assign pb   = {b1, b0};
   assign eq_o = eq & (pa == pb);
   // A decision made on a more significant pair is never overturned.
   assign gt_o = gt | (eq & (pa > pb));

endmodule

// File: rtl/serial_cmp2.sv
// Bit-serial unsigned magnitude comparator, two bits per clock, MSB pair first.
// Optional build macro: SERIAL_CMP2_EARLY_EXIT_EN (finish as soon as the result is decided).
module serial_cmp2
   import serial_cmp2_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq_o,
   output logic             gt_o,
   output logic             lt_o
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH / 2 - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("serial_cmp2: WIDTH must be even and at least 2");
      end
   endgenerate

   state_t          state;
   state_t          state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic            eq_r;
   logic            gt_r;
   logic [CW-1:0]   cnt;
   logic            slice_eq;
   logic            slice_gt;
   logic            accept;
   logic            last;

   cmp2_slice u_slice (
      .a1   (a_sh[WIDTH-1]),
      .a0   (a_sh[WIDTH-2]),
      .b1   (b_sh[WIDTH-1]),
      .b0   (b_sh[WIDTH-2]),
      .eq   (eq_r),
      .gt   (gt_r),
      .eq_o (slice_eq),
      .gt_o (slice_gt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
`ifdef SERIAL_CMP2_EARLY_EXIT_EN
            last = (cnt == '0) | ~slice_eq;
`else
            last = (cnt == '0);
`endif
            if (last) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         eq_r <= 1'b1;
         gt_r <= 1'b0;
         cnt  <= '0;
         done <= 1'b0;
         eq_o <= 1'b0;
         gt_o <= 1'b0;
         lt_o <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh <= a;
            b_sh <= b;
            eq_r <= 1'b1;
            gt_r <= 1'b0;
            cnt  <= CNT_LOAD;
            eq_o <= 1'b0;
            gt_o <= 1'b0;
            lt_o <= 1'b0;
         end else if (state == S_RUN) begin
            eq_r <= slice_eq;
            gt_r <= slice_gt;
            a_sh <= a_sh << 2;
            b_sh <= b_sh << 2;
            cnt  <= cnt - 1'b1;
            // Results are published only on the terminating edge so they stay one-hot.
            if (last) begin
               done <= 1'b1;
               eq_o <= slice_eq;
               gt_o <= slice_gt;
               lt_o <= ~slice_eq & ~slice_gt;
            end
         end
      end
   end

   assign busy = (state == S_RUN);

endmodule

// File: tb/tb_serial_cmp2.sv
// Self-checking bench for serial_cmp2: WIDTH=8 vector table and corner sequences, plus WIDTH=2 sweep.
module tb_serial_cmp2;

   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_GT = 3'b010;
   localparam logic [2:0] R_LT = 3'b001;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] res;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start2;
   logic [7:0] a8, b8;
   logic [1:0] a2, b2;
   logic       busy8, done8, eq8, gt8, lt8;
   logic       busy2, done2, eq2, gt2, lt2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [2:0] exp_q[$];
   int         cyc_q[$];
   logic [2:0] exp2_q[$];
   int         cyc2_q[$];
   logic       done8_prev = 1'b0;
   logic       done2_prev = 1'b0;

   vec_t vecs[10];

   serial_cmp2 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .eq_o(eq8), .gt_o(gt8), .lt_o(lt8)
   );

   serial_cmp2 #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .eq_o(eq2), .gt_o(gt2), .lt_o(lt2)
   );

   always #50 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
      if (a == b) return R_EQ;
      if (a > b)  return R_GT;
      return R_LT;
   endfunction

   function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef SERIAL_CMP2_EARLY_EXIT_EN
      for (int i = 0; i < 4; i++)
         if (a[7-2*i -: 2] != b[7-2*i -: 2]) return i + 1;
`endif
      return 4;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done8_prev) check("done8_one_cycle", done8, 1'b0);
      if (done8) begin
         if (exp_q.size() == 0) begin
            check("done8_unexpected", 1'b1, 1'b0);
         end else begin
            check("result8", {eq8, gt8, lt8}, exp_q.pop_front());
            check("latency8", cyc, cyc_q.pop_front());
            check("busy8_at_done", busy8, 1'b0);
         end
      end
      done8_prev = done8;
   end

   always @(negedge clk) begin
      if (done2_prev) check("done2_one_cycle", done2, 1'b0);
      if (done2) begin
         if (exp2_q.size() == 0) begin
            check("done2_unexpected", 1'b1, 1'b0);
         end else begin
            check("result2", {eq2, gt2, lt2}, exp2_q.pop_front());
            check("latency2", cyc, cyc2_q.pop_front());
         end
      end
      done2_prev = done2;
   end

   task automatic wait8();
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain8_timeout", exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] res);
      @(negedge clk);
      a8 = a; b8 = b; start8 = 1'b1;
      exp_q.push_back(res);
      cyc_q.push_back(cyc + 1 + exp_lat(a, b));
      @(negedge clk);
      start8 = 1'b0;
      check("busy8_after_accept", busy8, 1'b1);
      check("res8_cleared", {eq8, gt8, lt8}, 3'b000);
      wait8();
      @(negedge clk);
      check("res8_held", {eq8, gt8, lt8}, res);
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] res;
      res = {a == b, a > b, a < b};
      @(negedge clk);
      a2 = a; b2 = b; start2 = 1'b1;
      exp2_q.push_back(res);
      cyc2_q.push_back(cyc + 2);
      @(negedge clk);
      start2 = 1'b0;
      check("busy2_after_accept", busy2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (exp2_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain2_timeout", exp2_q.size(), 0);
      exp2_q.delete();
      cyc2_q.delete();
      @(negedge clk);
      check("res2_held", {eq2, gt2, lt2}, res);
   endtask

   initial begin
      int k, lat, acc2;
      vecs[0] = '{8'hA5, 8'hA5, R_EQ};
      vecs[1] = '{8'h80, 8'h7F, R_GT};
      vecs[2] = '{8'h3C, 8'h3D, R_LT};
      vecs[3] = '{8'h00, 8'h00, R_EQ};
      vecs[4] = '{8'hFF, 8'hFF, R_EQ};
      vecs[5] = '{8'hFF, 8'hFE, R_GT};
      vecs[6] = '{8'h01, 8'h02, R_LT};
      vecs[7] = '{8'hC0, 8'h3F, R_GT};
      for (int i = 8; i < 10; i++) begin
         vecs[i].a   = 8'($urandom_range(0, 255));
         vecs[i].b   = 8'($urandom_range(0, 255));
         vecs[i].res = model(vecs[i].a, vecs[i].b);
      end

      rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
      a8 = '0; b8 = '0; a2 = '0; b2 = '0;
      repeat (2) @(negedge clk);
      check("reset_busy8", busy8, 1'b0);
      check("reset_done8", done8, 1'b0);
      check("reset_res8", {eq8, gt8, lt8}, 3'b000);
      check("reset_res2", {busy2, done2, eq2, gt2, lt2}, 5'b00000);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_res8_before_first", {eq8, gt8, lt8}, 3'b000);

      for (int i = 0; i < 10; i++) run8(vecs[i].a, vecs[i].b, vecs[i].res);

      // start re-pulsed with other operands during RUN must be ignored
      @(negedge clk);
      a8 = 8'hA5; b8 = 8'hA4; start8 = 1'b1;
      exp_q.push_back(R_GT);
      cyc_q.push_back(cyc + 1 + exp_lat(8'hA5, 8'hA4));
      @(negedge clk);
      a8 = 8'h00; b8 = 8'hFF;
      check("repulse_busy", busy8, 1'b1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      start8 = 1'b0;
      wait8();
      repeat (6) @(negedge clk);
      check("repulse_idle", busy8, 1'b0);
      check("repulse_res", {eq8, gt8, lt8}, R_GT);

      // start held across the terminating edge: second compare starts one cycle after done
      @(negedge clk);
      a8 = 8'h3C; b8 = 8'h3D; start8 = 1'b1;
      k = cyc;
      lat = exp_lat(8'h3C, 8'h3D);
      acc2 = k + 1 + lat + 1;
      exp_q.push_back(R_LT); cyc_q.push_back(k + 1 + lat);
      exp_q.push_back(R_LT); cyc_q.push_back(acc2 + lat);
      for (int i = 0; i < 40; i++) begin
         if (cyc >= acc2) break;
         @(negedge clk);
      end
      start8 = 1'b0;
      check("held_start_busy", busy8, 1'b1);
      wait8();
      @(negedge clk);

      // asynchronous reset in the middle of a RUN discards the partial compare
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      exp_q.push_back(R_GT);
      cyc_q.push_back(cyc + 1 + exp_lat(8'hFF, 8'h00));
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      #10 rst = 1'b1;
      #1;
      check("midrst_busy", busy8, 1'b0);
      check("midrst_done", done8, 1'b0);
      check("midrst_res", {eq8, gt8, lt8}, 3'b000);
      exp_q.delete();
      cyc_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      run8(8'h00, 8'hFF, R_LT);

      for (int i = 0; i < 16; i++) run2(2'(i >> 2), 2'(i));

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
